// File: rtl/mfp_gpio_arbiter_if.sv
// rtl/mfp_gpio_arbiter_if.sv - requester-side request/response bundle for the GPIO arbiter
interface mfp_gpio_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 3
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_write;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][31:0]    req_wdata;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mfp_gpio_arbiter.sv
// rtl/mfp_gpio_arbiter.sv - round-robin arbiter sharing one GPIO register port
module mfp_gpio_arbiter #(
  parameter int NREQ   = 2,
  parameter int GPIO_W = 5,
  parameter int GPIO_R = 5,
  parameter int AW     = (((GPIO_W > GPIO_R) ? GPIO_W : GPIO_R) > 1) ?
                         $clog2((GPIO_W > GPIO_R) ? GPIO_W : GPIO_R) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  mfp_gpio_arbiter_if.slave        bus,
  output logic [31:0]              gpio_wd,
  output logic [GPIO_W-1:0]        gpio_we,
  input  logic [GPIO_R-1:0][31:0]  gpio_rd
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  owner;
  logic           write_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;

  logic           found;
  logic [PW-1:0]  winner;
  logic [PW-1:0]  next_ptr;
  logic [PW-1:0]  idx_p;
  int             idx;
  logic           accept;
  logic           wr_ok;
  logic           rd_ok;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    next_ptr = rr_ptr;
    idx      = 0;
    idx_p    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx   = (int'(rr_ptr) + i) % NREQ;
      idx_p = PW'(idx);
      if (!found && bus.req_valid[idx_p]) begin
        found    = 1'b1;
        winner   = idx_p;
        next_ptr = PW'((idx + 1) % NREQ);
      end
    end
  end

  assign accept        = (state == IDLE) && found && !rst;
  assign bus.req_ready = accept ? (NREQ'(1) << winner) : '0;

  assign wr_ok = write_q && (int'(addr_q) < GPIO_W);
  assign rd_ok = !write_q && (int'(addr_q) < GPIO_R);

  // Gated by rst so a reset landing in ACCESS never reaches the pin block.
  assign gpio_we = ((state == ACCESS) && wr_ok && !rst) ? (GPIO_W'(1) << addr_q) : '0;
  assign gpio_wd = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner   <= winner;
            write_q <= bus.req_write[winner];
            addr_q  <= bus.req_addr[winner];
            wdata_q <= bus.req_wdata[winner];
            rr_ptr  <= next_ptr;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          bus.rsp_rdata <= rd_ok ? gpio_rd[addr_q] : 32'h0;
          bus.rsp_err   <= !(wr_ok || rd_ok);
          bus.rsp_valid <= NREQ'(1) << owner;
          state         <= RESP;
        end
        RESP: begin
          bus.rsp_valid <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mfp_gpio_arbiter.sv
// tb/tb_mfp_gpio_arbiter.sv - directed vector bench for mfp_gpio_arbiter
module tb_mfp_gpio_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  mfp_gpio_arbiter_if #(.NREQ(2), .AW(3)) bus ();
  mfp_gpio_arbiter_if #(.NREQ(4), .AW(3)) bus4 ();

  logic [31:0]       gpio_wd;
  logic [4:0]        gpio_we;
  logic [31:0]       gpio_wd4;
  logic [4:0]        gpio_we4;
  logic [4:0][31:0]  pins;

  mfp_gpio_arbiter #(.NREQ(2), .GPIO_W(5), .GPIO_R(5)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gpio_wd(gpio_wd), .gpio_we(gpio_we), .gpio_rd(pins)
  );

  mfp_gpio_arbiter #(.NREQ(4), .GPIO_W(5), .GPIO_R(5)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .gpio_wd(gpio_wd4), .gpio_we(gpio_we4), .gpio_rd(pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin block: registers take the written value at the end of the ACCESS cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (gpio_we[i]) pins[i] <= gpio_wd;
  end

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [4:0]  we;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic txn(input int r, input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic got, output logic [4:0] we, output logic [31:0] wd,
                     output logic [4:0] we_after, output logic [1:0] rv,
                     output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    bus.req_valid[r] = 1'b1;
    bus.req_write[r] = w;
    bus.req_addr[r]  = a;
    bus.req_wdata[r] = d;
    #1;
    n = 0;
    while (bus.req_ready[r] !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = (bus.req_ready[r] === 1'b1);
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    #1;
    we = gpio_we;
    wd = gpio_wd;
    @(negedge clk);
    #1;
    we_after = gpio_we;
    rv = bus.rsp_valid;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  logic        got, er;
  logic [4:0]  we, we_after;
  logic [31:0] wd, rd;
  logic [1:0]  rv;
  int          cnt;
  int          g;

  initial begin
    checks = 0;
    passes = 0;
    vecs[0] = '{1'b1, 3'd0, 32'hA5A5_0001, 5'b00001, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 3'd0, 32'h0,         5'b00000, 32'hA5A5_0001, 1'b0};
    vecs[2] = '{1'b1, 3'd4, 32'hDEAD_BEEF, 5'b10000, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 3'd4, 32'h0,         5'b00000, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b1, 3'd7, 32'h1234_5678, 5'b00000, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 3'd6, 32'h0,         5'b00000, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 3'd5, 32'h0,         5'b00000, 32'h0,         1'b1};
    vecs[7] = '{1'b1, 3'd2, 32'h0000_0011, 5'b00100, 32'h0,         1'b0};
    vecs[8] = '{1'b1, 3'd3, 32'h0000_0022, 5'b01000, 32'h0,         1'b0};
    vecs[9] = '{1'b0, 3'd3, 32'h0,         5'b00000, 32'h0000_0022, 1'b0};

    bus.req_valid = '0;  bus.req_write = '0;  bus.req_addr = '0;  bus.req_wdata = '0;
    bus4.req_valid = '0; bus4.req_write = '0; bus4.req_addr = '0; bus4.req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready",     {62'h0, bus.req_ready}, 64'h0);
    chk("reset rsp_valid", {62'h0, bus.rsp_valid}, 64'h0);
    chk("reset rsp_rdata", {32'h0, bus.rsp_rdata}, 64'h0);
    chk("reset rsp_err",   {63'h0, bus.rsp_err},   64'h0);
    chk("reset gpio_wd",   {32'h0, gpio_wd},       64'h0);
    chk("reset gpio_we",   {59'h0, gpio_we},       64'h0);

    for (int i = 0; i < 10; i++) begin
      txn(0, vecs[i].w, vecs[i].a, vecs[i].d, got, we, wd, we_after, rv, rd, er);
      chk($sformatf("v%0d grant", i), {63'h0, got}, 64'h1);
      chk($sformatf("v%0d gpio_we", i), {59'h0, we}, {59'h0, vecs[i].we});
      chk($sformatf("v%0d gpio_we_after", i), {59'h0, we_after}, 64'h0);
      chk($sformatf("v%0d rsp_valid", i), {62'h0, rv}, 64'h1);
      chk($sformatf("v%0d rsp_rdata", i), {32'h0, rd}, {32'h0, vecs[i].rd});
      chk($sformatf("v%0d rsp_err", i), {63'h0, er}, {63'h0, vecs[i].er});
      if (vecs[i].w) chk($sformatf("v%0d gpio_wd", i), {32'h0, wd}, {32'h0, vecs[i].d});
    end

    // Simultaneous reads from a fresh reset: requester 0 first, requester 1 three cycles later.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.req_valid = 2'b11; bus.req_write = 2'b00;
    bus.req_addr[0] = 3'd2; bus.req_addr[1] = 3'd3;
    #1; chk("sim ready0", {62'h0, bus.req_ready}, 64'h1);
    @(negedge clk); bus.req_valid[0] = 1'b0;
    #1; chk("sim ready access", {62'h0, bus.req_ready}, 64'h0);
    @(negedge clk);
    #1; chk("sim ready resp", {62'h0, bus.req_ready}, 64'h0);
    chk("sim rsp_valid0", {62'h0, bus.rsp_valid}, 64'h1);
    chk("sim rdata0", {32'h0, bus.rsp_rdata}, 64'h11);
    @(negedge clk);
    #1; chk("sim ready1", {62'h0, bus.req_ready}, 64'h2);
    @(negedge clk); bus.req_valid[1] = 1'b0;
    @(negedge clk);
    #1; chk("sim rsp_valid1", {62'h0, bus.rsp_valid}, 64'h2);
    chk("sim rdata1", {32'h0, bus.rsp_rdata}, 64'h22);

    // Reset in the ACCESS cycle of a write leaves rr_ptr at 1 unless reset clears it.
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b1;
    bus.req_addr[0] = 3'd1;  bus.req_wdata[0] = 32'hCAFE_F00D;
    #1; chk("abort ready", {62'h0, bus.req_ready}, 64'h1);
    @(negedge clk); bus.req_valid[0] = 1'b0; rst = 1'b1;
    #1; chk("abort gpio_we", {59'h0, gpio_we}, 64'h0);
    @(negedge clk); rst = 1'b0;
    #1; chk("abort outputs zero",
            {bus.req_ready, bus.rsp_valid, bus.rsp_err, gpio_we} == '0 &&
            bus.rsp_rdata == 32'h0 && gpio_wd == 32'h0, 64'h1);
    cnt = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != 2'b00 || gpio_we != 5'b0) cnt++;
    end
    chk("abort no response", cnt, 64'h0);
    chk("abort pin untouched", {63'h0, pins[1] === 32'hCAFE_F00D}, 64'h0);
    bus.req_valid = 2'b11; bus.req_write = 2'b00; bus.req_addr = '0;
    #1; chk("abort next grant", {62'h0, bus.req_ready}, 64'h1);
    @(negedge clk); bus.req_valid = 2'b00;
    @(negedge clk);
    #1; chk("abort next rsp_valid", {62'h0, bus.rsp_valid}, 64'h1);
    chk("abort next rdata", {32'h0, bus.rsp_rdata}, 64'hA5A5_0001);

    // Requester 1 raises and withdraws entirely while requester 0 is in flight.
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b0; bus.req_addr[0] = 3'd4;
    #1; chk("wd ready0", {62'h0, bus.req_ready}, 64'h1);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_write[1] = 1'b1;
    bus.req_addr[1] = 3'd0;  bus.req_wdata[1] = 32'h0000_0BAD;
    #1; chk("wd ready access", {62'h0, bus.req_ready}, 64'h0);
    @(negedge clk); bus.req_valid[1] = 1'b0;
    #1; chk("wd rsp_valid", {62'h0, bus.rsp_valid}, 64'h1);
    chk("wd rdata", {32'h0, bus.rsp_rdata}, 64'hDEAD_BEEF);
    cnt = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus.req_ready != 2'b00 || bus.rsp_valid != 2'b00 || gpio_we != 5'b0) cnt++;
    end
    chk("wd no activity", cnt, 64'h0);
    chk("wd pin0 kept", {32'h0, pins[0]}, 64'hA5A5_0001);

    // Four requesters held valid: grants must rotate 0,1,2,3 three times.
    @(negedge clk);
    bus4.req_valid = 4'hF; bus4.req_write = 4'h0;
    for (int i = 0; i < 4; i++) bus4.req_addr[i] = 3'(i);
    g = 0;
    cnt = 0;
    #1;
    while (g < 12 && cnt < 60) begin
      if (bus4.req_ready != 4'h0) begin
        chk($sformatf("fair onehot %0d", g), $countones(bus4.req_ready), 64'h1);
        chk($sformatf("fair grant %0d", g), {60'h0, bus4.req_ready}, 64'h1 << (g % 4));
        g++;
      end
      @(negedge clk); #1;
      cnt++;
    end
    chk("fair grant count", g, 64'd12);
    bus4.req_valid = 4'h0;

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
